resource_dispatch: RTL and testbench

- Sits between the two `pipeline_top` instances and `shared_resource`.
- Arbitrates resource requests from both pipelines with round-robin fairness and issues one request per cycle to the resource.
- Records the source pipeline of every in-flight request in a tag FIFO and routes each resource result back to the pipeline that issued it.
- Drives the global stall when the in-flight budget is exhausted, and discards results belonging to flushed pipelines.

---
 rtl/resource_dispatch.sv | 120 ++++++++++++
 tb/tb_resource_dispatch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/resource_dispatch.sv
// Round-robin dispatcher between two pipelines and one in-order shared resource.
// A tag FIFO remembers the source of each in-flight request so results route back.
module resource_dispatch #(
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              req2_valid,
  input  logic [DATA_W-1:0] req2_data,
  output logic              req2_ready,
  input  logic              flush_1,
  input  logic              flush_2,
  output logic              res_in_valid,
  output logic [DATA_W-1:0] res_in_data,
  input  logic              res_out_valid,
  input  logic [DATA_W-1:0] res_out_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp2_valid,
  output logic [DATA_W-1:0] rsp2_data,
  output logic              stall,
  output logic              orphan_err
);
  // Handshake: a request transfers in any cycle where reqN_valid and reqN_ready
  // are both high; ready is combinational and never depends on a same-cycle pop.
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam int PTR_W = $clog2(TAG_DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic              tag_src_q  [TAG_DEPTH];
  logic              tag_live_q [TAG_DEPTH];
  logic              prio2_q;
  logic              res_in_valid_q;
  logic [DATA_W-1:0] res_in_data_q;
  logic              rsp1_valid_q, rsp2_valid_q;
  logic [DATA_W-1:0] rsp1_data_q, rsp2_data_q;
  logic              orphan_q;

  logic can_issue, elig1, elig2, grant1, grant2, push, pop, fifo_empty;
  logic head_src, head_live;

  always_comb begin
    can_issue  = (count_q < CNT_W'(TAG_DEPTH));
    elig1      = req1_valid & ~flush_1 & can_issue & ~reset;
    elig2      = req2_valid & ~flush_2 & can_issue & ~reset;
    // prio2_q high means port 1 was granted last, so port 2 wins a tie
    grant1     = elig1 & (~elig2 | ~prio2_q);
    grant2     = elig2 & (~elig1 | prio2_q);
    push       = grant1 | grant2;
    fifo_empty = (count_q == '0);
    pop        = res_out_valid & ~fifo_empty;
    head_src   = tag_src_q[rd_ptr_q];
    head_live  = tag_live_q[rd_ptr_q] & ~(head_src ? flush_2 : flush_1);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      prio2_q        <= 1'b0;
      res_in_valid_q <= 1'b0;
      res_in_data_q  <= '0;
      rsp1_valid_q   <= 1'b0;
      rsp2_valid_q   <= 1'b0;
      rsp1_data_q    <= '0;
      rsp2_data_q    <= '0;
      orphan_q       <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_src_q[i]  <= 1'b0;
        tag_live_q[i] <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      for (int i = 0; i < TAG_DEPTH; i++) begin
        if ((tag_src_q[i] & flush_2) | (~tag_src_q[i] & flush_1))
          tag_live_q[i] <= 1'b0;
      end
      // The write slot is always free when push is high, so this cannot clash with the loop above
      if (push) begin
        tag_src_q[wr_ptr_q]  <= grant2;
        tag_live_q[wr_ptr_q] <= grant2 ? ~flush_2 : ~flush_1;
      end

      if (grant1)      prio2_q <= 1'b1;
      else if (grant2) prio2_q <= 1'b0;

      res_in_valid_q <= push;
      if (push) res_in_data_q <= grant2 ? req2_data : req1_data;

      rsp1_valid_q <= pop & head_live & ~head_src;
      rsp2_valid_q <= pop & head_live & head_src;
      if (pop & head_live & ~head_src) rsp1_data_q <= res_out_data;
      if (pop & head_live & head_src)  rsp2_data_q <= res_out_data;

      if (res_out_valid & fifo_empty) orphan_q <= 1'b1;
    end
  end

  assign req1_ready   = grant1;
  assign req2_ready   = grant2;
  assign stall        = (count_q == CNT_W'(TAG_DEPTH));
  assign res_in_valid = res_in_valid_q;
  assign res_in_data  = res_in_data_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp1_data    = rsp1_data_q;
  assign rsp2_valid   = rsp2_valid_q;
  assign rsp2_data    = rsp2_data_q;
  assign orphan_err   = orphan_q;

endmodule

// File: tb/tb_resource_dispatch.sv
// Bench for resource_dispatch: directed scenarios plus a random phase, with a
// reference model of the tag FIFO and arbitration feeding expected-value queues.
module tb_resource_dispatch;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic src;
    logic live;
  } tag_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req1_valid = 1'b0, req2_valid = 1'b0;
  logic [W-1:0] req1_data = '0, req2_data = '0;
  logic         req1_ready, req2_ready;
  logic         flush_1 = 1'b0, flush_2 = 1'b0;
  logic         res_in_valid;
  logic [W-1:0] res_in_data;
  logic         res_out_valid = 1'b0;
  logic [W-1:0] res_out_data = '0;
  logic         rsp1_valid, rsp2_valid;
  logic [W-1:0] rsp1_data, rsp2_data;
  logic         stall, orphan_err;

  resource_dispatch #(.DATA_W(W), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .req2_valid(req2_valid), .req2_data(req2_data), .req2_ready(req2_ready),
    .flush_1(flush_1), .flush_2(flush_2),
    .res_in_valid(res_in_valid), .res_in_data(res_in_data),
    .res_out_valid(res_out_valid), .res_out_data(res_out_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .rsp2_valid(rsp2_valid), .rsp2_data(rsp2_data),
    .stall(stall), .orphan_err(orphan_err)
  );

  // clock
  always #5 clk = ~clk;

  // reference model and scoreboard state
  tag_t         m_tags[$];
  logic [W-1:0] res_pend_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rsp1_q[$];
  logic [W-1:0] exp_rsp2_q[$];
  logic         m_prio2 = 1'b0;
  logic         m_orphan = 1'b0;
  logic [W-1:0] m_in_data = '0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req1_valid = 1'b0; req2_valid = 1'b0;
    flush_1 = 1'b0; flush_2 = 1'b0;
    res_out_valid = 1'b0;
    @(posedge clk); #1;
    m_tags.delete(); res_pend_q.delete(); exp_q.delete();
    exp_rsp1_q.delete(); exp_rsp2_q.delete();
    m_prio2 = 1'b0; m_orphan = 1'b0; m_in_data = '0;
    check("rst_res_in_valid", res_in_valid, 0);
    check("rst_res_in_data", res_in_data, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp1_data", rsp1_data, 0);
    check("rst_rsp2_valid", rsp2_valid, 0);
    check("rst_rsp2_data", rsp2_data, 0);
    check("rst_stall", stall, 0);
    check("rst_orphan_err", orphan_err, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_req2_ready", req2_ready, 0);
  endtask

  // One clock of stimulus; the bench plays the resource, answering in issue order with data*2.
  task automatic cycle(input logic v1, input logic [W-1:0] d1, input logic v2,
                       input logic [W-1:0] d2, input logic f1, input logic f2, input logic ret);
    logic         can, e1, e2, g1, g2, exp_in_v, exp_r1, exp_r2;
    logic [W-1:0] rd;
    tag_t         head;
    @(negedge clk);
    reset = 1'b0;
    if (ret && res_pend_q.size() > 0) rd = res_pend_q.pop_front() << 1;
    else rd = 32'hDEAD_0000 | W'($urandom_range(0, 255));
    req1_valid = v1; req1_data = d1;
    req2_valid = v2; req2_data = d2;
    flush_1 = f1; flush_2 = f2;
    res_out_valid = ret; res_out_data = rd;
    #1;
    can = (m_tags.size() < DEPTH);
    e1 = v1 && !f1 && can;
    e2 = v2 && !f2 && can;
    g1 = e1 && (!e2 || !m_prio2);
    g2 = e2 && (!e1 || m_prio2);
    check("req1_ready", req1_ready, g1);
    check("req2_ready", req2_ready, g2);
    check("stall", stall, m_tags.size() == DEPTH);

    exp_in_v = g1 || g2;
    if (g1) begin exp_q.push_back(d1); res_pend_q.push_back(d1); end
    if (g2) begin exp_q.push_back(d2); res_pend_q.push_back(d2); end
    exp_r1 = 1'b0; exp_r2 = 1'b0;
    if (ret) begin
      if (m_tags.size() == 0) m_orphan = 1'b1;
      else begin
        head = m_tags.pop_front();
        if (head.live && !(head.src ? f2 : f1)) begin
          if (head.src) begin exp_r2 = 1'b1; exp_rsp2_q.push_back(rd); end
          else begin exp_r1 = 1'b1; exp_rsp1_q.push_back(rd); end
        end
      end
    end
    for (int i = 0; i < m_tags.size(); i++)
      if ((m_tags[i].src && f2) || (!m_tags[i].src && f1)) m_tags[i].live = 1'b0;
    if (g1) begin m_tags.push_back(tag_t'{src: 1'b0, live: 1'b1}); m_prio2 = 1'b1; end
    if (g2) begin m_tags.push_back(tag_t'{src: 1'b1, live: 1'b1}); m_prio2 = 1'b0; end

    @(posedge clk); #1;
    check("res_in_valid", res_in_valid, exp_in_v);
    if (exp_in_v) m_in_data = exp_q.pop_front();
    check("res_in_data", res_in_data, m_in_data);
    check("rsp1_valid", rsp1_valid, exp_r1);
    if (exp_r1) check("rsp1_data", rsp1_data, exp_rsp1_q.pop_front());
    check("rsp2_valid", rsp2_valid, exp_r2);
    if (exp_r2) check("rsp2_data", rsp2_data, exp_rsp2_q.pop_front());
    check("orphan_err", orphan_err, m_orphan);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    // single request routes back to port 1
    do_reset();
    cycle(1, 32'h11, 0, '0, 0, 0, 0);
    cycle(0, '0, 0, '0, 0, 0, 1);
    idle(2);

    // fairness to full, then full with simultaneous pop, then drain
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 32'h100 + W'(i), 1, 32'h200 + W'(i), 0, 0, 0);
    cycle(1, 32'h150, 1, 32'h250, 0, 0, 0);
    cycle(1, 32'h160, 1, 32'h260, 0, 0, 1);
    cycle(1, 32'h170, 1, 32'h270, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, '0, 0, 0, 1);
    idle(1);

    // flush of port 2 drops its results, port 1 still routes
    do_reset();
    cycle(0, '0, 1, 32'hA, 0, 0, 0);
    cycle(0, '0, 1, 32'hB, 0, 0, 0);
    cycle(1, 32'hC, 0, '0, 0, 0, 0);
    cycle(0, '0, 1, 32'hE, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, '0, 0, 0, 1);
    // flush in the same cycle as the response pop
    cycle(0, '0, 1, 32'hD, 0, 0, 0);
    cycle(0, '0, 0, '0, 0, 1, 1);
    idle(1);

    // orphan result is sticky
    do_reset();
    cycle(0, '0, 0, '0, 0, 0, 1);
    idle(3);
    cycle(1, 32'h33, 0, '0, 0, 0, 0);
    cycle(0, '0, 0, '0, 0, 0, 1);

    // reset with requests in flight, then a late result
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 32'h40 + W'(i), 0, '0, 0, 0, 0);
    do_reset();
    cycle(0, '0, 0, '0, 0, 0, 1);
    idle(1);

    // random traffic with occasional flushes
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), W'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
            (res_pend_q.size() > 0) && ($urandom_range(0, 2) != 0));
    end
    while (res_pend_q.size() > 0) cycle(0, '0, 0, '0, 0, 0, 1);
    idle(1);
    check("exp_queues_drained", W'(exp_q.size() + exp_rsp1_q.size() + exp_rsp2_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
